battle_master_ctrl: RTL
=======================

BATTLE_MASTER_CTRL -- requirements
Module: battle_master_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-002 SHALL have port clr, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port A_sw, input, 10: player A switches; ship layout in setup, cumulative attack pattern in play.
REQ-004 SHALL have ports BTN1A/BTN2A/BTN3A, input, 1 each: A confirm / fire / restart buttons.
REQ-005 SHALL have ports BTN1B/BTN2B/BTN3B, input, 1 each: B buttons, same meaning, forwarded from the slave board.
REQ-006 SHALL have port B_Attack, input, 10: slave attack register contents.
REQ-007 SHALL have port LivB, input, 1: player B has at least one ship cell remaining.
REQ-008 SHALL have port A_Attack, output, 10: cumulative accepted attacks by A, driven to the slave.
REQ-009 SHALL have port LDR2B, output, 1: one-cycle load strobe for the slave attack register.
REQ-010 SHALL have port ST, output, 1: 0 = slave loads ships from switches; 1 = play.
REQ-011 SHALL have port clrB, output, 1: slave clear, high during clr and for the restart pulse.
REQ-012 SHALL have ports DispA/DispB, output, 3 each: word codes for each board's seven-segment display.
REQ-013 SHALL have port LivA, output, 1: OR-reduction of ship register A.

Function
REQ-014 SHALL pass every button through btn_edge; the resulting pulse lasts exactly 1 cycle, 2 cycles after the button is first sampled high.
REQ-015 SHALL implement states SETUP_A, SETUP_B, TURN_A, SETTLE_A, TURN_B, LOAD_B, CHECK_B, WIN_A, WIN_B.
REQ-016 SETUP_A: on BTN1A pulse with A_sw != 0, load shipsA <= A_sw and go to SETUP_B. If A_sw == 0, ignore the pulse and drive DispA = BAD for that cycle.
REQ-017 SETUP_B: on BTN1B pulse, go to TURN_A with ST = 1 from that transition onward. ST = 0 in SETUP_A and SETUP_B only.
REQ-018 TURN_A: on BTN2A pulse, compute new = A_sw & ~A_Attack.
- If new is one-hot: A_Attack <= A_Attack | new; go to SETTLE_A.
- Otherwise: stay in TURN_A; DispA = BAD until the next pulse.
REQ-019 SETTLE_A SHALL count 3 cycles (parameter SETTLE = 3) to cover slave register and comparator latency, then sample LivB. LivB = 0 -> WIN_A; else -> TURN_B.
REQ-020 TURN_B: on BTN2B pulse, assert LDR2B for exactly 1 cycle and go to LOAD_B. LOAD_B lasts 1 cycle, then go to CHECK_B.
REQ-021 CHECK_B: compute newB = B_Attack & ~prevB.
- If newB is one-hot: prevB <= prevB | newB; shipsA <= shipsA & ~newB; go to WIN_B if the result is 0, else TURN_A.
- Otherwise: return to TURN_B with DispB = BAD.
REQ-022 Display codes: SHIPS = 0, FIRE = 1, WAIT = 2, BAD = 3, WIN = 4, LOSE = 5.
- Setup: SHIPS on the pending player's board, WAIT on the other.
- Turn: FIRE on the active board, WAIT on the other.
- Win: WIN on the winner's board, LOSE on the loser's.
REQ-023 WIN_A/WIN_B: on BTN3A or BTN3B pulse, clrB = 1 for 1 cycle, clear all registers, go to SETUP_A.
REQ-024 Fire pulses from the non-active player SHALL be ignored. Simultaneous A and B pulses SHALL be resolved by the current state only.

Reset
REQ-025 While clr = 1 (synchronous), the block SHALL hold:
- state = SETUP_A; shipsA = A_Attack = prevB = 0; settle counter = 0.
- LDR2B = 0, ST = 0, clrB = 1, DispA = SHIPS, DispB = WAIT, LivA = 0.
- btn_edge synchroniser flops = 0.
REQ-026 Asserting clr in any state mid-game SHALL abort the game with no residual strobe on the next cycle.

Structure
REQ-027 Package battle_pkg SHALL hold the state enum, the display word-code constants, and SETTLE.
REQ-028 Sub-module btn_edge (2-flop synchroniser plus rising-edge detector) SHALL be instantiated 6 times.
REQ-029 One-hot check SHALL be (x != 0) && ((x & (x-1)) == 0) at 10-bit width.

Verification
REQ-030 Setup: A_sw = 10'h003 + BTN1A, then BTN1B -> shipsA = 003, ST = 1, DispA = FIRE, DispB = WAIT.
REQ-031 Invalid fire: A_Attack = 001, A_sw = 006, BTN2A -> A_Attack unchanged, DispA = BAD, state TURN_A.
REQ-032 Valid fire: A_Attack = 001, A_sw = 003, BTN2A -> A_Attack = 003; LivB = 0 after 3 cycles -> DispA = WIN, DispB = LOSE.
REQ-033 B turn: BTN2B -> LDR2B high exactly 1 cycle; B_Attack = 002 with shipsA = 003 -> shipsA = 001, LivA = 1, DispA = FIRE.
REQ-034 Restart: clr pulsed in SETTLE_A, or BTN3A in WIN_A -> state SETUP_A, A_Attack = 0, clrB high 1 cycle (held during clr).

Source files
------------

// File: rtl/battle_pkg.sv
// Shared types and constants for the battleship master controller:
// FSM state encoding, display word codes, settle length and the one-hot test.
package battle_pkg;

    typedef enum logic [3:0] {
        SETUP_A  = 4'd0,
        SETUP_B  = 4'd1,
        TURN_A   = 4'd2,
        SETTLE_A = 4'd3,
        TURN_B   = 4'd4,
        LOAD_B   = 4'd5,
        CHECK_B  = 4'd6,
        WIN_A    = 4'd7,
        WIN_B    = 4'd8
    } state_t;

    localparam logic [2:0] DISP_SHIPS = 3'd0;
    localparam logic [2:0] DISP_FIRE  = 3'd1;
    localparam logic [2:0] DISP_WAIT  = 3'd2;
    localparam logic [2:0] DISP_BAD   = 3'd3;
    localparam logic [2:0] DISP_WIN   = 3'd4;
    localparam logic [2:0] DISP_LOSE  = 3'd5;

    localparam int         SETTLE      = 3;
    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE - 1);

    // True when exactly one of the ten bits is set.
    function automatic logic is_one_hot(input logic [9:0] x);
        return (x != 10'd0) && ((x & (x - 10'd1)) == 10'd0);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector; the registered
// pulse is one cycle wide and starts two cycles after the first high sample.
module btn_edge (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic pulse
);

    logic sync0_q, sync0_d;
    logic sync1_q, sync1_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    // Next-state for the synchroniser chain and edge detector.
    always_comb begin
        sync0_d = btn;
        sync1_d = sync0_q;
        prev_d  = sync1_q;
        pulse_d = sync1_q & ~prev_q;
    end

    // Synchroniser, history and pulse registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/battle_master_ctrl.sv
// Master-board game controller: ship setup, alternating turns with attack
// validation, win detection and restart; all outputs are registered.
module battle_master_ctrl
    import battle_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] A_sw,
    input  logic       BTN1A,
    input  logic       BTN2A,
    input  logic       BTN3A,
    input  logic       BTN1B,
    input  logic       BTN2B,
    input  logic       BTN3B,
    input  logic [9:0] B_Attack,
    input  logic       LivB,
    output logic [9:0] A_Attack,
    output logic       LDR2B,
    output logic       ST,
    output logic       clrB,
    output logic [2:0] DispA,
    output logic [2:0] DispB,
    output logic       LivA
);

    logic p1a, p2a, p3a, p1b, p2b, p3b;

    btn_edge u_b1a (.clk(clk), .clr(clr), .btn(BTN1A), .pulse(p1a));
    btn_edge u_b2a (.clk(clk), .clr(clr), .btn(BTN2A), .pulse(p2a));
    btn_edge u_b3a (.clk(clk), .clr(clr), .btn(BTN3A), .pulse(p3a));
    btn_edge u_b1b (.clk(clk), .clr(clr), .btn(BTN1B), .pulse(p1b));
    btn_edge u_b2b (.clk(clk), .clr(clr), .btn(BTN2B), .pulse(p2b));
    btn_edge u_b3b (.clk(clk), .clr(clr), .btn(BTN3B), .pulse(p3b));

    state_t     state_q, state_d;
    logic [9:0] ships_q, ships_d;
    logic [9:0] att_q, att_d;
    logic [9:0] prevb_q, prevb_d;
    logic [1:0] cnt_q, cnt_d;
    logic       bad_a_q, bad_a_d;
    logic       bad_b_q, bad_b_d;
    logic       ldr_q, ldr_d;
    logic       st_q, st_d;
    logic       clrb_q, clrb_d;
    logic [2:0] dispa_q, dispa_d;
    logic [2:0] dispb_q, dispb_d;
    logic       liva_q, liva_d;
    logic [9:0] new_a_s, new_b_s, hit_ships_s;

    // Game FSM next-state and register updates.
    always_comb begin
        state_d     = state_q;
        ships_d     = ships_q;
        att_d       = att_q;
        prevb_d     = prevb_q;
        cnt_d       = cnt_q;
        bad_a_d     = bad_a_q;
        bad_b_d     = bad_b_q;
        ldr_d       = 1'b0;
        clrb_d      = 1'b0;
        new_a_s     = A_sw & ~att_q;
        new_b_s     = B_Attack & ~prevb_q;
        hit_ships_s = ships_q & ~new_b_s;
        case (state_q)
            SETUP_A: begin
                // An empty layout is refused and flagged for a single cycle.
                if (p1a && (A_sw != 10'd0)) begin
                    ships_d = A_sw;
                    bad_a_d = 1'b0;
                    state_d = SETUP_B;
                end else begin
                    bad_a_d = p1a;
                end
            end
            SETUP_B: begin
                if (p1b) state_d = TURN_A;
                else     state_d = SETUP_B;
            end
            TURN_A: begin
                if (p2a) begin
                    if (is_one_hot(new_a_s)) begin
                        att_d   = att_q | new_a_s;
                        bad_a_d = 1'b0;
                        cnt_d   = 2'd0;
                        state_d = SETTLE_A;
                    end else begin
                        bad_a_d = 1'b1;
                    end
                end else begin
                    state_d = TURN_A;
                end
            end
            SETTLE_A: begin
                // Let the slave register and its hit comparator catch up before trusting LivB.
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 2'd0;
                    state_d = LivB ? TURN_B : WIN_A;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            TURN_B: begin
                if (p2b) begin
                    ldr_d   = 1'b1;
                    bad_b_d = 1'b0;
                    state_d = LOAD_B;
                end else begin
                    state_d = TURN_B;
                end
            end
            LOAD_B: state_d = CHECK_B;
            CHECK_B: begin
                if (is_one_hot(new_b_s)) begin
                    prevb_d = prevb_q | new_b_s;
                    ships_d = hit_ships_s;
                    state_d = (hit_ships_s == 10'd0) ? WIN_B : TURN_A;
                end else begin
                    bad_b_d = 1'b1;
                    state_d = TURN_B;
                end
            end
            WIN_A, WIN_B: begin
                if (p3a || p3b) begin
                    clrb_d  = 1'b1;
                    ships_d = 10'd0;
                    att_d   = 10'd0;
                    prevb_d = 10'd0;
                    cnt_d   = 2'd0;
                    bad_a_d = 1'b0;
                    bad_b_d = 1'b0;
                    state_d = SETUP_A;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = SETUP_A;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs track it.
    always_comb begin
        st_d    = !((state_d == SETUP_A) || (state_d == SETUP_B));
        liva_d  = |ships_d;
        dispa_d = DISP_WAIT;
        dispb_d = DISP_WAIT;
        case (state_d)
            SETUP_A:                 dispa_d = bad_a_d ? DISP_BAD : DISP_SHIPS;
            SETUP_B:                 dispb_d = DISP_SHIPS;
            TURN_A:                  dispa_d = bad_a_d ? DISP_BAD : DISP_FIRE;
            SETTLE_A:                dispa_d = DISP_FIRE;
            TURN_B:                  dispb_d = bad_b_d ? DISP_BAD : DISP_FIRE;
            LOAD_B, CHECK_B:         dispb_d = DISP_FIRE;
            WIN_A: begin
                dispa_d = DISP_WIN;
                dispb_d = DISP_LOSE;
            end
            WIN_B: begin
                dispa_d = DISP_LOSE;
                dispb_d = DISP_WIN;
            end
            default: begin
                dispa_d = DISP_SHIPS;
                dispb_d = DISP_WAIT;
            end
        endcase
    end

    // State, game registers and registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= SETUP_A;
            ships_q <= 10'd0;
            att_q   <= 10'd0;
            prevb_q <= 10'd0;
            cnt_q   <= 2'd0;
            bad_a_q <= 1'b0;
            bad_b_q <= 1'b0;
            ldr_q   <= 1'b0;
            st_q    <= 1'b0;
            clrb_q  <= 1'b1;
            dispa_q <= DISP_SHIPS;
            dispb_q <= DISP_WAIT;
            liva_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ships_q <= ships_d;
            att_q   <= att_d;
            prevb_q <= prevb_d;
            cnt_q   <= cnt_d;
            bad_a_q <= bad_a_d;
            bad_b_q <= bad_b_d;
            ldr_q   <= ldr_d;
            st_q    <= st_d;
            clrb_q  <= clrb_d;
            dispa_q <= dispa_d;
            dispb_q <= dispb_d;
            liva_q  <= liva_d;
        end
    end

    assign A_Attack = att_q;
    assign LDR2B    = ldr_q;
    assign ST       = st_q;
    assign clrB     = clrb_q;
    assign DispA    = dispa_q;
    assign DispB    = dispb_q;
    assign LivA     = liva_q;

endmodule
